// File: rtl/mul_16bit_acc.sv
// mul_16bit_acc: accumulates a programmed number of signed products from the
// 16-bit Wallace tree multiplier into a wide signed accumulator. The sum is
// presented downstream over a valid/ready handshake.
//
// Optional build macro: MUL_ACC_SAT_EN
//   defined   - the accumulator saturates to the signed max/min on overflow
//   undefined - the accumulator wraps modulo 2^ACC_WIDTH
// o_ovf is reported in both builds.
//
// Handshake: o_valid is high for the whole DONE state and stays high until
// the cycle where o_valid && i_ready. o_acc/o_cnt/o_ovf are stable while
// o_valid is high. i_clr overrides both the handshake and any i_end.
module mul_16bit_acc #(
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 40,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_clr,
    input  logic [CNT_WIDTH-1:0]  i_len,
    input  logic                  i_end,
    input  logic [DATA_WIDTH-1:0] i_res,
    input  logic                  i_ready,
    output logic                  o_busy,
    output logic                  o_valid,
    output logic [ACC_WIDTH-1:0]  o_acc,
    output logic [CNT_WIDTH-1:0]  o_cnt,
    output logic                  o_ovf,
    output logic                  o_drop
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

`ifdef MUL_ACC_SAT_EN
    localparam logic [ACC_WIDTH-1:0] SAT_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] SAT_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
`endif

    logic [1:0]            state_q, state_d;
    logic [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]  len_q, len_d;
    logic                  ovf_q, ovf_d;
    logic                  drop_q, drop_d;

    logic [ACC_WIDTH-1:0]  res_ext;
    logic [ACC_WIDTH-1:0]  sum;
    logic [CNT_WIDTH-1:0]  cnt_inc;
    logic                  add_ovf;

    // Sign-extend the product, form the candidate sum and detect signed overflow
    always_comb begin
        res_ext = ACC_WIDTH'($signed(i_res));
        sum     = acc_q + res_ext;
        cnt_inc = cnt_q + CNT_WIDTH'(1);
        add_ovf = (acc_q[ACC_WIDTH-1] == res_ext[ACC_WIDTH-1]) &&
                  (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
    end

    // Next-state logic: i_clr restarts from any state and wins over i_end/handshake
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        drop_d  = drop_q;
        if (i_clr) begin
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            drop_d  = 1'b0;
            len_d   = i_len;
            state_d = (i_len != '0) ? S_ACC : S_DONE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_end) drop_d = 1'b1;
                end
                S_ACC: begin
                    if (i_end) begin
`ifdef MUL_ACC_SAT_EN
                        // Clamp toward the sign of the pre-add value; later adds start from here
                        if (add_ovf) acc_d = acc_q[ACC_WIDTH-1] ? SAT_MIN : SAT_MAX;
                        else         acc_d = sum;
`else
                        acc_d = sum;
`endif
                        cnt_d = cnt_inc;
                        if (add_ovf) ovf_d = 1'b1;
                        if (cnt_inc == len_q) state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    if (i_end)   drop_d  = 1'b1;
                    if (i_ready) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
        end
    end

    assign o_busy  = (state_q == S_ACC);
    assign o_valid = (state_q == S_DONE);
    assign o_acc   = acc_q;
    assign o_cnt   = cnt_q;
    assign o_ovf   = ovf_q;
    assign o_drop  = drop_q;

endmodule

// File: tb/tb_mul_16bit_acc.sv
// Bench for mul_16bit_acc: a 40-bit accumulator instance (a_*) and a 34-bit
// instance (b_*) driven by the same inputs. Table vectors, hand-written
// corner sequences and random runs against a scoreboard queue.
module tb_mul_16bit_acc;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic [7:0]  len;
  logic        end_p;
  logic [31:0] res;
  logic        ready;

  logic        a_busy, a_valid, a_ovf, a_drop;
  logic [39:0] a_acc;
  logic [7:0]  a_cnt;
  logic        b_busy, b_valid, b_ovf, b_drop;
  logic [33:0] b_acc;
  logic [7:0]  b_cnt;

  int checks = 0;
  int errors = 0;
  logic [39:0] exp_q[$];

  mul_16bit_acc #(.DATA_WIDTH(32), .ACC_WIDTH(40), .CNT_WIDTH(8)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_len(len), .i_end(end_p),
    .i_res(res), .i_ready(ready), .o_busy(a_busy), .o_valid(a_valid),
    .o_acc(a_acc), .o_cnt(a_cnt), .o_ovf(a_ovf), .o_drop(a_drop)
  );

  mul_16bit_acc #(.DATA_WIDTH(32), .ACC_WIDTH(34), .CNT_WIDTH(8)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_len(len), .i_end(end_p),
    .i_res(res), .i_ready(ready), .o_busy(b_busy), .o_valid(b_valid),
    .o_acc(b_acc), .o_cnt(b_cnt), .o_ovf(b_ovf), .o_drop(b_drop)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  len;
    logic [31:0] prod[4];
    logic [39:0] exp_acc;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[5];

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic start_run(input logic [7:0] l);
    clr = 1'b1;
    len = l;
    tick();
    clr = 1'b0;
  endtask

  task automatic send(input logic [31:0] r);
    end_p = 1'b1;
    res   = r;
    tick();
    end_p = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!a_valid && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (!a_valid) begin
      errors++;
      $display("FAIL %s: o_valid timeout got 0 expected 1", name);
    end
  endtask

  // scoreboard pop and compare
  task automatic sb_check(input string name, input logic [7:0] exp_cnt);
    logic [39:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty got 0x%0h expected entry", name, a_acc);
    end else begin
      e = exp_q.pop_front();
      check({name, "_acc"}, a_acc, e);
      check({name, "_cnt"}, {32'd0, a_cnt}, {32'd0, exp_cnt});
    end
  endtask

  initial begin
    logic [39:0] sum;
    logic [7:0]  rl;
    logic [31:0] rr;

    vecs[0] = '{len: 8'd2, prod: '{32'h0000002A, 32'hFFFFFFE2, 32'h0, 32'h0},
                exp_acc: 40'h000000000C, exp_ovf: 1'b0};
    vecs[1] = '{len: 8'd4, prod: '{32'h1, 32'h1, 32'h1, 32'h1},
                exp_acc: 40'h0000000004, exp_ovf: 1'b0};
    vecs[2] = '{len: 8'd3, prod: '{32'h80000000, 32'h80000000, 32'h80000000, 32'h0},
                exp_acc: 40'hFE80000000, exp_ovf: 1'b0};
    vecs[3] = '{len: 8'd1, prod: '{32'hFFFFFFFF, 32'h0, 32'h0, 32'h0},
                exp_acc: 40'hFFFFFFFFFF, exp_ovf: 1'b0};
    vecs[4] = '{len: 8'd4, prod: '{32'h7FFFFFFF, 32'h80000000, 32'h12345678, 32'hFFFFFFFF},
                exp_acc: 40'h0012345676, exp_ovf: 1'b0};

    rst_n = 1'b0; clr = 1'b0; len = '0; end_p = 1'b0; res = '0; ready = 1'b0;
    tick();
    tick();
    check("rst_busy",  {39'd0, a_busy},  40'd0);
    check("rst_valid", {39'd0, a_valid}, 40'd0);
    check("rst_acc",   a_acc,            40'd0);
    check("rst_cnt",   {32'd0, a_cnt},   40'd0);
    check("rst_flags", {38'd0, a_ovf, a_drop}, 40'd0);
    rst_n = 1'b1;
    tick();

    // table vectors, ready low until result checked
    for (int v = 0; v < 5; v++) begin
      start_run(vecs[v].len);
      check($sformatf("v%0d_busy", v), {39'd0, a_busy}, 40'd1);
      for (int k = 0; k < int'(vecs[v].len); k++) send(vecs[v].prod[k]);
      exp_q.push_back(vecs[v].exp_acc);
      check($sformatf("v%0d_latency", v), {39'd0, a_valid}, 40'd1);
      sb_check($sformatf("v%0d", v), vecs[v].len);
      check($sformatf("v%0d_ovf", v), {39'd0, a_ovf}, {39'd0, vecs[v].exp_ovf});
      ready = 1'b1;
      tick();
      ready = 1'b0;
      check($sformatf("v%0d_release", v), {39'd0, a_valid}, 40'd0);
    end

    // hold: result stable with ready low for 5 cycles
    start_run(8'd4);
    for (int k = 0; k < 4; k++) send(32'h1);
    for (int k = 0; k < 5; k++) begin
      check("hold_valid", {39'd0, a_valid}, 40'd1);
      check("hold_acc", a_acc, 40'd4);
      tick();
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("hold_idle_valid", {39'd0, a_valid}, 40'd0);
    check("hold_idle_busy",  {39'd0, a_busy},  40'd0);
    check("hold_retained",   a_acc,            40'd4);

    // zero length: straight to DONE; i_end there only flags drop
    start_run(8'd0);
    check("len0_valid", {39'd0, a_valid}, 40'd1);
    check("len0_acc",   a_acc,            40'd0);
    send(32'h55);
    check("len0_drop",      {39'd0, a_drop},  40'd1);
    check("len0_acc_after", a_acc,            40'd0);
    check("len0_still_valid", {39'd0, a_valid}, 40'd1);

    // abort: restart wins over coincident i_end, and clears drop
    start_run(8'd3);
    check("abort_drop_clr", {39'd0, a_drop}, 40'd0);
    send(32'h10);
    clr = 1'b1; len = 8'd1; end_p = 1'b1; res = 32'h20;
    tick();
    clr = 1'b0; end_p = 1'b0;
    check("abort_acc0", a_acc,           40'd0);
    check("abort_cnt0", {32'd0, a_cnt},  40'd0);
    check("abort_busy", {39'd0, a_busy}, 40'd1);
    send(32'h05);
    exp_q.push_back(40'h5);
    check("abort_valid", {39'd0, a_valid}, 40'd1);
    sb_check("abort", 8'd1);

    // overflow on the 34-bit instance; 40-bit instance does not overflow
    start_run(8'd5);
    for (int k = 0; k < 5; k++) send(32'h7FFFFFFF);
    check("ovf34_flag", {39'd0, b_ovf}, 40'd1);
`ifdef MUL_ACC_SAT_EN
    check("ovf34_acc", {6'd0, b_acc}, 40'h01FFFFFFFF);
`else
    check("ovf34_acc", {6'd0, b_acc}, 40'h027FFFFFFB);
`endif
    check("ovf40_flag", {39'd0, a_ovf}, 40'd0);
    check("ovf40_acc",  a_acc,          40'h027FFFFFFB);
    start_run(8'd1);
    check("ovf_clr", {39'd0, b_ovf}, 40'd0);
    send(32'h0);

    // random runs with bubbles, model sums in 40 bits
    ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      rl = 8'($urandom_range(1, 8));
      start_run(rl);
      sum = '0;
      for (int k = 0; k < int'(rl); k++) begin
        if ($urandom_range(0, 2) == 0) tick();
        rr = $urandom;
        sum = sum + {{8{rr[31]}}, rr};
        send(rr);
      end
      exp_q.push_back(sum);
      wait_valid($sformatf("rnd%0d", r));
      sb_check($sformatf("rnd%0d", r), rl);
      tick();
    end
    ready = 1'b0;

    // asynchronous reset in the middle of a run
    start_run(8'd3);
    send(32'h1234);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_acc",   a_acc, 40'd0);
    check("arst_flags", {35'd0, a_busy, a_valid, a_ovf, a_drop, b_busy}, 40'd0);
    check("arst_cnt",   {32'd0, a_cnt}, 40'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("arst_idle", {38'd0, a_busy, a_valid}, 40'd0);
    send(32'h7);
    check("arst_drop_idle", {39'd0, a_drop}, 40'd1);
    check("arst_acc_idle",  a_acc,           40'd0);

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL sb_leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
